// File: rtl/eth_switch_pkg.sv
// Shared types, header constants and the round-robin search used by the
// Ethernet AXI-Stream channel switch.
package eth_switch_pkg;

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        REPLAY = 2'd1,
        PASS   = 2'd2,
        DROP   = 2'd3
    } rx_state_e;

    localparam int ETH_HDR_LEN  = 14;
    localparam int ETYPE_HI_IDX = 12;

    // First set bit of req at or above ptr, wrapping within n entries (n <= 8).
    function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] ptr,
                                           input int unsigned n);
        logic [2:0]  res;
        logic        found;
        int unsigned idx;
        res   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = (32'(ptr) + k) % n;
            if (!found && (k < n) && req[idx[2:0]]) begin
                res   = idx[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_axis_rr_arb.sv
// Frame-granular round-robin arbiter: the grant is registered, held until
// release_i, and the search restarts one past the channel just released.
module eth_axis_rr_arb
    import eth_switch_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         release_i,
    output logic         grant_valid_o,
    output logic [2:0]   grant_o
);

    logic [7:0] req8;
    logic [2:0] ptr_q;
    logic [2:0] grant_q;
    logic       gv_q;

    always_comb begin
        req8        = '0;
        req8[N-1:0] = req_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            grant_q <= '0;
            gv_q    <= 1'b0;
        end else if (!gv_q) begin
            if (|req_i) begin
                gv_q    <= 1'b1;
                grant_q <= rr_next(req8, ptr_q, N);
            end
        end else if (release_i) begin
            gv_q  <= 1'b0;
            ptr_q <= (grant_q == 3'(N - 1)) ? 3'd0 : grant_q + 3'd1;
        end
    end

    assign grant_valid_o = gv_q;
    assign grant_o       = grant_q;

endmodule

// File: rtl/eth_axis_chan_switch.sv
// N-channel AXI-Stream switch between one MAC user port and CHANNELS engines:
// EtherType-steered RX with header replay, round-robin frame merge on TX.
module eth_axis_chan_switch
    import eth_switch_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int DROP_UNMATCHED = 1,
    parameter int DEFAULT_CH     = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              mac_rx_tdata,
    input  logic                    mac_rx_tvalid,
    output logic                    mac_rx_tready,
    input  logic                    mac_rx_tlast,
    input  logic                    mac_rx_tuser,
    output logic [7:0]              mac_tx_tdata,
    output logic                    mac_tx_tvalid,
    input  logic                    mac_tx_tready,
    output logic                    mac_tx_tlast,
    output logic                    mac_tx_tuser,
    output logic [8*CHANNELS-1:0]   ch_rx_tdata,
    output logic [CHANNELS-1:0]     ch_rx_tvalid,
    input  logic [CHANNELS-1:0]     ch_rx_tready,
    output logic [CHANNELS-1:0]     ch_rx_tlast,
    output logic [CHANNELS-1:0]     ch_rx_tuser,
    input  logic [8*CHANNELS-1:0]   ch_tx_tdata,
    input  logic [CHANNELS-1:0]     ch_tx_tvalid,
    output logic [CHANNELS-1:0]     ch_tx_tready,
    input  logic [CHANNELS-1:0]     ch_tx_tlast,
    input  logic [CHANNELS-1:0]     ch_tx_tuser,
    input  logic [16*CHANNELS-1:0]  cfg_ethertype,
    input  logic [CHANNELS-1:0]     cfg_enable,
    output logic [CNT_WIDTH-1:0]    rx_drop_count,
    output logic [CNT_WIDTH-1:0]    rx_runt_count,
    output logic [1:0]              rx_state_dbg
);

    // Handshake: a beat moves on tvalid & tready at posedge clk; sources hold
    // their beat until accepted, and no tready output depends on an output tvalid.
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    rx_state_e      state_q;
    logic [3:0]     idx_q;
    logic [2:0]     sel_q;
    logic           run_q;
    logic [7:0]     hdr_q [ETH_HDR_LEN];
    logic [CNT_WIDTH-1:0] drop_q;
    logic [CNT_WIDTH-1:0] runt_q;

    logic           sel_ready;
    logic           match_hit;
    logic [2:0]     match_ch;
    logic [7:0]     rx_data;

    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++)
            if (sel_q == 3'(i)) sel_ready = ch_rx_tready[i];
    end

    // Descending scan so the lowest matching channel wins.
    always_comb begin
        match_hit = 1'b0;
        match_ch  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cfg_enable[i] &&
                cfg_ethertype[16*i +: 16] == {hdr_q[ETYPE_HI_IDX], mac_rx_tdata}) begin
                match_hit = 1'b1;
                match_ch  = 3'(i);
            end
        end
    end

    always_comb begin
        case (state_q)
            HDR:     mac_rx_tready = run_q;
            PASS:    mac_rx_tready = sel_ready;
            DROP:    mac_rx_tready = 1'b1;
            default: mac_rx_tready = 1'b0;
        endcase
        ch_rx_tvalid = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_q == 3'(i)) begin
                if (state_q == REPLAY)    ch_rx_tvalid[i] = 1'b1;
                else if (state_q == PASS) ch_rx_tvalid[i] = mac_rx_tvalid;
            end
        end
        rx_data = (state_q == REPLAY) ? hdr_q[idx_q] : mac_rx_tdata;
    end

    assign ch_rx_tdata  = {CHANNELS{rx_data}};
    assign ch_rx_tlast  = {CHANNELS{(state_q == PASS) & mac_rx_tlast}};
    assign ch_rx_tuser  = {CHANNELS{(state_q == PASS) & mac_rx_tuser}};
    assign rx_drop_count = drop_q;
    assign rx_runt_count = runt_q;
    assign rx_state_dbg  = state_q;

    // run_q keeps tready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR;
            idx_q   <= '0;
            sel_q   <= '0;
            run_q   <= 1'b0;
            drop_q  <= '0;
            runt_q  <= '0;
            for (int i = 0; i < ETH_HDR_LEN; i++) hdr_q[i] <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                HDR: if (mac_rx_tvalid && run_q) begin
                    hdr_q[idx_q] <= mac_rx_tdata;
                    if (mac_rx_tlast) begin
                        idx_q <= '0;
                        if (runt_q != '1) runt_q <= runt_q + CNT_ONE;
                    end else if (idx_q == 4'(ETH_HDR_LEN - 1)) begin
                        idx_q <= '0;
                        if (match_hit) begin
                            sel_q   <= match_ch;
                            state_q <= REPLAY;
                        end else if (DROP_UNMATCHED != 0) begin
                            state_q <= DROP;
                            if (drop_q != '1) drop_q <= drop_q + CNT_ONE;
                        end else begin
                            sel_q   <= 3'(DEFAULT_CH);
                            state_q <= REPLAY;
                        end
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                REPLAY: if (sel_ready) begin
                    if (idx_q == 4'(ETH_HDR_LEN - 1)) begin
                        idx_q   <= '0;
                        state_q <= PASS;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                PASS: if (mac_rx_tvalid && sel_ready && mac_rx_tlast) state_q <= HDR;
                DROP: if (mac_rx_tvalid && mac_rx_tlast) state_q <= HDR;
                default: state_q <= HDR;
            endcase
        end
    end

    logic       grant_valid;
    logic [2:0] grant;
    logic       tx_release;

    eth_axis_rr_arb #(.N(CHANNELS)) u_tx_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (ch_tx_tvalid),
        .release_i     (tx_release),
        .grant_valid_o (grant_valid),
        .grant_o       (grant)
    );

    always_comb begin
        mac_tx_tdata  = '0;
        mac_tx_tvalid = 1'b0;
        mac_tx_tlast  = 1'b0;
        mac_tx_tuser  = 1'b0;
        ch_tx_tready  = '0;
        if (grant_valid) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (grant == 3'(i)) begin
                    mac_tx_tdata    = ch_tx_tdata[8*i +: 8];
                    mac_tx_tvalid   = ch_tx_tvalid[i];
                    mac_tx_tlast    = ch_tx_tlast[i];
                    mac_tx_tuser    = ch_tx_tuser[i];
                    ch_tx_tready[i] = mac_tx_tready;
                end
            end
        end
    end

    assign tx_release = mac_tx_tvalid & mac_tx_tready & mac_tx_tlast;

endmodule

// File: tb/tb_eth_axis_chan_switch.sv
// Directed bench for eth_axis_chan_switch: RX steering/drop/runt, TX round-robin,
// back-pressure and mid-frame reset, checked against queues the bench builds itself.
module tb_eth_axis_chan_switch;

    localparam int CH = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     mac_rx_tdata;
    logic           mac_rx_tvalid, mac_rx_tready, mac_rx_tlast, mac_rx_tuser;
    logic [7:0]     mac_tx_tdata;
    logic           mac_tx_tvalid, mac_tx_tready, mac_tx_tlast, mac_tx_tuser;
    logic [8*CH-1:0]  ch_rx_tdata;
    logic [CH-1:0]    ch_rx_tvalid, ch_rx_tready, ch_rx_tlast, ch_rx_tuser;
    logic [8*CH-1:0]  ch_tx_tdata;
    logic [CH-1:0]    ch_tx_tvalid, ch_tx_tready, ch_tx_tlast, ch_tx_tuser;
    logic [16*CH-1:0] cfg_ethertype;
    logic [CH-1:0]    cfg_enable;
    logic [15:0]      rx_drop_count, rx_runt_count;
    logic [1:0]       rx_state_dbg;

    typedef logic [9:0] beat_q_t[$];
    beat_q_t rx0_exp_q, rx1_exp_q, tx_exp_q;
    beat_q_t rx0_got_q, rx1_got_q, tx_got_q;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    bit rx1_rand = 1'b0;
    bit tx_rand  = 1'b0;

    always #5 clk = ~clk;

    eth_axis_chan_switch #(.CHANNELS(CH), .DROP_UNMATCHED(1), .DEFAULT_CH(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mac_rx_tdata(mac_rx_tdata), .mac_rx_tvalid(mac_rx_tvalid), .mac_rx_tready(mac_rx_tready),
        .mac_rx_tlast(mac_rx_tlast), .mac_rx_tuser(mac_rx_tuser),
        .mac_tx_tdata(mac_tx_tdata), .mac_tx_tvalid(mac_tx_tvalid), .mac_tx_tready(mac_tx_tready),
        .mac_tx_tlast(mac_tx_tlast), .mac_tx_tuser(mac_tx_tuser),
        .ch_rx_tdata(ch_rx_tdata), .ch_rx_tvalid(ch_rx_tvalid), .ch_rx_tready(ch_rx_tready),
        .ch_rx_tlast(ch_rx_tlast), .ch_rx_tuser(ch_rx_tuser),
        .ch_tx_tdata(ch_tx_tdata), .ch_tx_tvalid(ch_tx_tvalid), .ch_tx_tready(ch_tx_tready),
        .ch_tx_tlast(ch_tx_tlast), .ch_tx_tuser(ch_tx_tuser),
        .cfg_ethertype(cfg_ethertype), .cfg_enable(cfg_enable),
        .rx_drop_count(rx_drop_count), .rx_runt_count(rx_runt_count),
        .rx_state_dbg(rx_state_dbg)
    );

    // Monitor: sampled on the falling edge, i.e. the beat that moves on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ch_rx_tvalid[0] && ch_rx_tready[0])
                rx0_got_q.push_back({ch_rx_tuser[0], ch_rx_tlast[0], ch_rx_tdata[7:0]});
            if (ch_rx_tvalid[1] && ch_rx_tready[1])
                rx1_got_q.push_back({ch_rx_tuser[1], ch_rx_tlast[1], ch_rx_tdata[15:8]});
            if (mac_tx_tvalid && mac_tx_tready)
                tx_got_q.push_back({mac_tx_tuser, mac_tx_tlast, mac_tx_tdata});
            if (mac_rx_tvalid && !mac_rx_tready)
                stall_cnt++;
        end
    end

    initial begin
        ch_rx_tready  = '1;
        mac_tx_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ch_rx_tready[0] = 1'b1;
            ch_rx_tready[1] = rx1_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            mac_tx_tready   = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic int first_diff(input beat_q_t a, input beat_q_t b);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++)
            if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] tx_byte(input int ch, input int f, input int k);
        return 8'(ch * 128 + (f * 7 + k) % 128);
    endfunction

    task automatic clear_queues();
        rx0_exp_q.delete(); rx1_exp_q.delete(); tx_exp_q.delete();
        rx0_got_q.delete(); rx1_got_q.delete(); tx_got_q.delete();
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rx_beat(input logic [7:0] d, input logic l, input logic u);
        int n;
        n = 0;
        mac_rx_tdata  = d;
        mac_rx_tvalid = 1'b1;
        mac_rx_tlast  = l;
        mac_rx_tuser  = u;
        @(negedge clk);
        while (!mac_rx_tready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL rx_beat_timeout: mac_rx_tready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        mac_rx_tvalid = 1'b0;
        mac_rx_tlast  = 1'b0;
        mac_rx_tuser  = 1'b0;
    endtask

    // dest: 0/1 = channel expected to receive it, -1 = nobody.
    task automatic send_frame(input int len, input logic [15:0] et, input logic user,
                              input logic [7:0] base, input int dest);
        logic [7:0] b;
        logic       l, u;
        for (int k = 0; k < len; k++) begin
            b = (k == 12) ? et[15:8] : (k == 13) ? et[7:0] : 8'(int'(base) + k);
            l = (k == len - 1);
            u = l ? user : 1'b0;
            if (dest == 0) rx0_exp_q.push_back({u, l, b});
            if (dest == 1) rx1_exp_q.push_back({u, l, b});
            rx_beat(b, l, u);
        end
    endtask

    task automatic tx_frames(input int ch, input int nfr, input int len);
        int n;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < len; k++) begin
                ch_tx_tdata[8*ch +: 8] = tx_byte(ch, f, k);
                ch_tx_tvalid[ch] = 1'b1;
                ch_tx_tlast[ch]  = (k == len - 1);
                ch_tx_tuser[ch]  = (k == len - 1) && f[0];
                n = 0;
                @(negedge clk);
                while (!ch_tx_tready[ch] && n < 2000) begin
                    n++;
                    @(negedge clk);
                end
                if (n >= 2000) begin
                    checks++; errors++;
                    $display("FAIL tx_beat_timeout: ch%0d tready stayed 0 for %0d cycles, required 1", ch, n);
                end
                @(posedge clk);
                #1;
                ch_tx_tvalid[ch] = 1'b0;
                ch_tx_tlast[ch]  = 1'b0;
                ch_tx_tuser[ch]  = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mac_rx_tdata = '0; mac_rx_tvalid = 1'b0; mac_rx_tlast = 1'b0; mac_rx_tuser = 1'b0;
        ch_tx_tdata = '0; ch_tx_tvalid = 2'b11; ch_tx_tlast = '0; ch_tx_tuser = '0;
        cfg_ethertype = {16'h88B5, 16'h0800};
        cfg_enable = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mac_rx_tready !== 1'b0) begin errors++; $display("FAIL reset_mac_rx_tready got %b exp 0", mac_rx_tready); end
        checks++; if (mac_tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mac_tx_tvalid got %b exp 0", mac_tx_tvalid); end
        checks++; if (ch_rx_tvalid !== 2'b00) begin errors++; $display("FAIL reset_ch_rx_tvalid got %b exp 00", ch_rx_tvalid); end
        checks++; if (ch_tx_tready !== 2'b00) begin errors++; $display("FAIL reset_ch_tx_tready got %b exp 00", ch_tx_tready); end
        checks++; if (rx_drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", rx_drop_count); end
        checks++; if (rx_runt_count !== 16'd0) begin errors++; $display("FAIL reset_runt_count got %0d exp 0", rx_runt_count); end
        checks++; if (rx_state_dbg !== 2'd0) begin errors++; $display("FAIL reset_rx_state got %0d exp 0", rx_state_dbg); end
        ch_tx_tvalid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_steer();
        int d;
        clear_queues();
        send_frame(64, 16'h88B5, 1'b1, 8'h10, 1);
        settle();
        d = first_diff(rx1_got_q, rx1_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL steer_ch1_data diff at beat %0d got %0d beats exp %0d", d, rx1_got_q.size(), rx1_exp_q.size()); end
        checks++; if (rx1_got_q.size() != 64) begin errors++; $display("FAIL steer_ch1_len got %0d exp 64", rx1_got_q.size()); end
        checks++; if (rx0_got_q.size() != 0) begin errors++; $display("FAIL steer_ch0_idle got %0d beats exp 0", rx0_got_q.size()); end
    endtask

    task automatic test_drop();
        int d;
        clear_queues();
        stall_cnt = 0;
        send_frame(40, 16'h86DD, 1'b0, 8'h20, -1);
        settle();
        checks++; if (rx0_got_q.size() + rx1_got_q.size() != 0) begin errors++; $display("FAIL drop_no_output got %0d beats exp 0", rx0_got_q.size() + rx1_got_q.size()); end
        checks++; if (rx_drop_count !== 16'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", rx_drop_count); end
        checks++; if (stall_cnt != 0) begin errors++; $display("FAIL drop_tready_stalls got %0d exp 0", stall_cnt); end
        send_frame(50, 16'h0800, 1'b1, 8'h40, 0);
        settle();
        d = first_diff(rx0_got_q, rx0_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL drop_next_ch0 diff at beat %0d got %0d beats exp %0d", d, rx0_got_q.size(), rx0_exp_q.size()); end
        // A disabled channel no longer matches its EtherType.
        cfg_enable = 2'b01;
        send_frame(30, 16'h88B5, 1'b0, 8'h50, -1);
        settle();
        cfg_enable = 2'b11;
        checks++; if (rx_drop_count !== 16'd2) begin errors++; $display("FAIL disabled_drop_count got %0d exp 2", rx_drop_count); end
        checks++; if (rx1_got_q.size() != 0) begin errors++; $display("FAIL disabled_ch1_idle got %0d beats exp 0", rx1_got_q.size()); end
    endtask

    task automatic test_runt();
        int d;
        clear_queues();
        send_frame(10, 16'h0800, 1'b0, 8'h60, -1);
        settle();
        checks++; if (rx_runt_count !== 16'd1) begin errors++; $display("FAIL runt10_count got %0d exp 1", rx_runt_count); end
        checks++; if (rx0_got_q.size() + rx1_got_q.size() != 0) begin errors++; $display("FAIL runt10_no_output got %0d beats exp 0", rx0_got_q.size() + rx1_got_q.size()); end
        send_frame(14, 16'h0800, 1'b0, 8'h70, -1);
        settle();
        checks++; if (rx_runt_count !== 16'd2) begin errors++; $display("FAIL runt14_count got %0d exp 2", rx_runt_count); end
        send_frame(60, 16'h88B5, 1'b0, 8'h80, 1);
        send_frame(15, 16'h0800, 1'b1, 8'h90, 0);
        settle();
        d = first_diff(rx1_got_q, rx1_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL runt_next_ch1 diff at beat %0d got %0d beats exp %0d", d, rx1_got_q.size(), rx1_exp_q.size()); end
        d = first_diff(rx0_got_q, rx0_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL min_frame_ch0 diff at beat %0d got %0d beats exp %0d", d, rx0_got_q.size(), rx0_exp_q.size()); end
        checks++; if (rx_drop_count !== 16'd2) begin errors++; $display("FAIL runt_drop_count got %0d exp 2", rx_drop_count); end
    endtask

    task automatic test_tx_rr();
        int d;
        clear_queues();
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 20; k++)
                    tx_exp_q.push_back({(k == 19) && (f % 2 == 1), k == 19, tx_byte(c, f, k)});
        fork
            tx_frames(0, 3, 20);
            tx_frames(1, 3, 20);
        join
        settle();
        d = first_diff(tx_got_q, tx_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL tx_rr_order diff at beat %0d got %0d beats exp %0d", d, tx_got_q.size(), tx_exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int d;
        clear_queues();
        for (int f = 0; f < 20; f++)
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 12; k++)
                    tx_exp_q.push_back({(k == 11) && (f % 2 == 1), k == 11, tx_byte(c, f, k)});
        rx1_rand = 1'b1;
        tx_rand  = 1'b1;
        fork
            begin
                for (int fr = 0; fr < 60; fr++)
                    send_frame($urandom_range(15, 40), (fr % 2 == 1) ? 16'h88B5 : 16'h0800,
                               1'($urandom_range(0, 1)), 8'(fr * 3), fr % 2);
            end
            tx_frames(0, 20, 12);
            tx_frames(1, 20, 12);
        join
        rx1_rand = 1'b0;
        tx_rand  = 1'b0;
        settle();
        d = first_diff(rx0_got_q, rx0_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL b2b_rx_ch0 diff at beat %0d got %0d beats exp %0d", d, rx0_got_q.size(), rx0_exp_q.size()); end
        d = first_diff(rx1_got_q, rx1_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL b2b_rx_ch1 diff at beat %0d got %0d beats exp %0d", d, rx1_got_q.size(), rx1_exp_q.size()); end
        d = first_diff(tx_got_q, tx_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL b2b_tx diff at beat %0d got %0d beats exp %0d", d, tx_got_q.size(), tx_exp_q.size()); end
        checks++; if (rx_runt_count !== 16'd2) begin errors++; $display("FAIL b2b_runt_count got %0d exp 2", rx_runt_count); end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        clear_queues();
        for (int k = 0; k < 30; k++)
            rx_beat((k == 12) ? 8'h08 : (k == 13) ? 8'h00 : 8'(k), 1'b0, 1'b0);
        mac_rx_tdata  = 8'd30;
        mac_rx_tvalid = 1'b1;
        #2;
        checks++; if (ch_rx_tvalid !== 2'b01) begin errors++; $display("FAIL mid_pass_valid got %b exp 01", ch_rx_tvalid); end
        rst_n = 1'b0;
        #1;
        checks++; if (ch_rx_tvalid !== 2'b00) begin errors++; $display("FAIL mid_rst_ch_rx_tvalid got %b exp 00", ch_rx_tvalid); end
        checks++; if (mac_rx_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_mac_rx_tready got %b exp 0", mac_rx_tready); end
        checks++; if (rx_drop_count !== 16'd0) begin errors++; $display("FAIL mid_rst_drop_count got %0d exp 0", rx_drop_count); end
        mac_rx_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_queues();
        send_frame(30, 16'h88B5, 1'b1, 8'hA0, 1);
        settle();
        d = first_diff(rx1_got_q, rx1_exp_q);
        checks++; if (d != -1) begin errors++; $display("FAIL post_rst_ch1 diff at beat %0d got %0d beats exp %0d", d, rx1_got_q.size(), rx1_exp_q.size()); end
        checks++; if (rx0_got_q.size() != 0) begin errors++; $display("FAIL post_rst_ch0_idle got %0d beats exp 0", rx0_got_q.size()); end
        checks++; if (rx_runt_count !== 16'd0) begin errors++; $display("FAIL post_rst_runt_count got %0d exp 0", rx_runt_count); end
        checks++; if (rx_drop_count !== 16'd0) begin errors++; $display("FAIL post_rst_drop_count got %0d exp 0", rx_drop_count); end
    endtask

    initial begin
        test_reset();
        test_steer();
        test_drop();
        test_runt();
        test_tx_rr();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
